uart_reg_block: RTL and testbench

Register file that consumes the native register bus (reg_addr/reg_wdata/reg_be/reg_we/reg_re) produced by the APB slave adapter. It exposes the UART control, status and data registers, and buffers TX and RX bytes in two synchronous FIFOs. It sits between the adapter and the UART TX/RX bit engines, and raises a level interrupt.

---
 rtl/uart_pkg.sv | 48 ++++
 rtl/uart_sync_fifo.sv | 83 ++++++++
 rtl/uart_reg_block.sv | 157 +++++++++++++++
 tb/tb_uart_reg_block.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART register block.
// Holds register byte offsets, field bit positions for CTRL, STATUS and
// IRQ_STAT/IRQ_EN, the STATUS count field positions, and a byte-merge helper.
package uart_pkg;

    // Register byte offsets; only address bits [4:2] are decoded.
    localparam logic [4:0] ADDR_DATA     = 5'h00;
    localparam logic [4:0] ADDR_STATUS   = 5'h04;
    localparam logic [4:0] ADDR_CTRL     = 5'h08;
    localparam logic [4:0] ADDR_BAUD     = 5'h0C;
    localparam logic [4:0] ADDR_IRQ_EN   = 5'h10;
    localparam logic [4:0] ADDR_IRQ_STAT = 5'h14;

    // CTRL fields
    localparam int unsigned CTRL_TX_EN  = 0;
    localparam int unsigned CTRL_RX_EN  = 1;
    localparam int unsigned CTRL_TX_CLR = 2;
    localparam int unsigned CTRL_RX_CLR = 3;

    // STATUS fields
    localparam int unsigned ST_TX_FULL      = 0;
    localparam int unsigned ST_TX_EMPTY     = 1;
    localparam int unsigned ST_RX_FULL      = 2;
    localparam int unsigned ST_RX_EMPTY     = 3;
    localparam int unsigned ST_TX_COUNT_LSB = 8;
    localparam int unsigned ST_RX_COUNT_LSB = 16;

    // IRQ_STAT / IRQ_EN fields; bits 2..4 are sticky write-1-to-clear.
    localparam int unsigned IRQ_RX_NOT_EMPTY = 0;
    localparam int unsigned IRQ_TX_EMPTY     = 1;
    localparam int unsigned IRQ_RX_OVERRUN   = 2;
    localparam int unsigned IRQ_FRAME_ERR    = 3;
    localparam int unsigned IRQ_TX_OVERFLOW  = 4;

    // Replace a byte with new data when its byte enable is set.
    function automatic logic [7:0] merge_byte(input logic [7:0] old_val,
                                              input logic [7:0] new_val,
                                              input logic       en);
        logic [7:0] res;
        if (en) begin
            res = new_val;
        end else begin
            res = old_val;
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO used for both the UART TX and RX byte queues.
// Ports: clk/rst_n (async active-low reset), clr (synchronous flush, wins
// over push/pop), push/wdata, pop/rdata (head, combinational), full, empty,
// count (0..DEPTH).
// A push when full is accepted only if a pop happens in the same cycle.
// When empty, rdata keeps showing the most recently popped entry.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [AW-1:0] PTR_ONE_C = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] last_r;
    logic             full_s;
    logic             empty_s;
    logic             pop_ok_s;
    logic             push_ok_s;

    assign full_s    = (count_r == DEPTH_C);
    assign empty_s   = (count_r == {CW{1'b0}});
    assign pop_ok_s  = pop && !empty_s && !clr;
    assign push_ok_s = push && (!full_s || pop_ok_s) && !clr;

    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;
    assign rdata = empty_s ? last_r : mem_r[rd_ptr_r];

    // Storage array write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer, occupancy and last-popped registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            last_r   <= {WIDTH{1'b0}};
        end else if (clr) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
                last_r   <= mem_r[rd_ptr_r];
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_reg_block.sv
// UART register file on the native register bus from the APB adapter.
// Ports: pclk/presetn (async active-low reset); reg_addr/reg_wdata/reg_be/
// reg_we/reg_re bus inputs and combinational reg_rdata; tx_data/tx_valid/
// tx_ready to the TX engine; rx_data/rx_valid/rx_frame_err from the RX
// engine; tx_en, rx_en, baud_div configuration outputs; registered irq.
module uart_reg_block
    import uart_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [15:0] BAUD_RESET = 16'd868
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic [ADDR_WIDTH-1:0]   reg_addr,
    input  logic [DATA_WIDTH-1:0]   reg_wdata,
    input  logic [DATA_WIDTH/8-1:0] reg_be,
    input  logic                    reg_we,
    input  logic                    reg_re,
    output logic [DATA_WIDTH-1:0]   reg_rdata,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    input  logic                    rx_frame_err,
    output logic                    tx_en,
    output logic                    rx_en,
    output logic [15:0]             baud_div,
    output logic                    irq
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [4:0]    off_s;
    logic          wr_ctrl_s, wr_baud_s, wr_irq_en_s, wr_irq_stat_s;
    logic          phase_r;
    logic [1:0]    ctrl_r;
    logic [15:0]   baud_r;
    logic [4:0]    irq_en_r;
    logic [2:0]    sticky_r;       // {tx_overflow, frame_err, rx_overrun}
    logic [2:0]    sticky_set_s;
    logic [2:0]    sticky_w1c_s;
    logic [2:0]    sticky_nxt_s;
    logic [4:0]    irq_stat_s;
    logic          irq_r;
    logic          tx_push_s, tx_pop_s, tx_clr_s, tx_full_s, tx_empty_s;
    logic          rx_push_s, rx_pop_s, rx_clr_s, rx_full_s, rx_empty_s;
    logic [7:0]    tx_head_s, rx_head_s;
    logic [CW-1:0] tx_count_s, rx_count_s;
    logic [31:0]   rdata_s;
    logic          unused_s;

    assign unused_s = ^{reg_addr[ADDR_WIDTH-1:5], reg_addr[1:0],
                        reg_wdata[DATA_WIDTH-1:16], reg_be[DATA_WIDTH/8-1:2]};

    assign off_s         = {reg_addr[4:2], 2'b00};
    assign wr_ctrl_s     = reg_we && (off_s == ADDR_CTRL) && reg_be[0];
    assign wr_baud_s     = reg_we && (off_s == ADDR_BAUD);
    assign wr_irq_en_s   = reg_we && (off_s == ADDR_IRQ_EN) && reg_be[0];
    assign wr_irq_stat_s = reg_we && (off_s == ADDR_IRQ_STAT) && reg_be[0];

    assign tx_clr_s  = wr_ctrl_s && reg_wdata[CTRL_TX_CLR];
    assign rx_clr_s  = wr_ctrl_s && reg_wdata[CTRL_RX_CLR];
    assign tx_push_s = reg_we && (off_s == ADDR_DATA) && reg_be[0];
    assign tx_valid  = ctrl_r[CTRL_TX_EN] && !tx_empty_s;
    assign tx_pop_s  = tx_valid && tx_ready;
    assign tx_data   = tx_head_s;
    assign rx_push_s = rx_valid && ctrl_r[CTRL_RX_EN];
    // Pop only in the access cycle (phase 1) so each 2-cycle read pops once.
    assign rx_pop_s  = reg_re && phase_r && (off_s == ADDR_DATA) && !rx_empty_s;

    assign tx_en     = ctrl_r[CTRL_TX_EN];
    assign rx_en     = ctrl_r[CTRL_RX_EN];
    assign baud_div  = baud_r;
    assign irq       = irq_r;

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(pclk), .rst_n(presetn), .clr(tx_clr_s), .push(tx_push_s),
        .pop(tx_pop_s), .wdata(reg_wdata[7:0]), .rdata(tx_head_s),
        .full(tx_full_s), .empty(tx_empty_s), .count(tx_count_s)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(pclk), .rst_n(presetn), .clr(rx_clr_s), .push(rx_push_s),
        .pop(rx_pop_s), .wdata(rx_data), .rdata(rx_head_s),
        .full(rx_full_s), .empty(rx_empty_s), .count(rx_count_s)
    );

    // Sticky flag update: a set in the same cycle as its W1C wins.
    always_comb begin
        sticky_set_s = 3'b000;
        sticky_w1c_s = 3'b000;
        sticky_set_s[0] = rx_push_s && rx_full_s && !rx_pop_s && !rx_clr_s;
        sticky_set_s[1] = rx_frame_err;
        sticky_set_s[2] = tx_push_s && tx_full_s && !tx_pop_s && !tx_clr_s;
        if (wr_irq_stat_s) begin
            sticky_w1c_s = reg_wdata[IRQ_TX_OVERFLOW:IRQ_RX_OVERRUN];
        end else begin
            sticky_w1c_s = 3'b000;
        end
        sticky_nxt_s = (sticky_r & ~sticky_w1c_s) | sticky_set_s;
    end

    assign irq_stat_s = {sticky_r, tx_empty_s, !rx_empty_s};

    // Combinational read mux; unmapped offsets return zero.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (off_s)
            ADDR_DATA:     rdata_s[8:0] = {!rx_empty_s, rx_head_s};
            ADDR_STATUS: begin
                rdata_s[ST_TX_FULL]  = tx_full_s;
                rdata_s[ST_TX_EMPTY] = tx_empty_s;
                rdata_s[ST_RX_FULL]  = rx_full_s;
                rdata_s[ST_RX_EMPTY] = rx_empty_s;
                rdata_s[ST_TX_COUNT_LSB +: CW] = tx_count_s;
                rdata_s[ST_RX_COUNT_LSB +: CW] = rx_count_s;
            end
            ADDR_CTRL:     rdata_s[1:0]  = ctrl_r;
            ADDR_BAUD:     rdata_s[15:0] = baud_r;
            ADDR_IRQ_EN:   rdata_s[4:0]  = irq_en_r;
            ADDR_IRQ_STAT: rdata_s[4:0]  = irq_stat_s;
            default:       rdata_s = 32'h0000_0000;
        endcase
    end

    assign reg_rdata = DATA_WIDTH'(rdata_s);

    // Configuration, sticky flags, read phase and interrupt registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            phase_r  <= 1'b0;
            ctrl_r   <= 2'b00;
            baud_r   <= BAUD_RESET;
            irq_en_r <= 5'b00000;
            sticky_r <= 3'b000;
            irq_r    <= 1'b0;
        end else begin
            phase_r  <= reg_re ? !phase_r : 1'b0;
            sticky_r <= sticky_nxt_s;
            irq_r    <= |(irq_stat_s & irq_en_r);
            if (wr_ctrl_s) begin
                ctrl_r <= reg_wdata[CTRL_RX_EN:CTRL_TX_EN];
            end
            if (wr_baud_s) begin
                baud_r <= {merge_byte(baud_r[15:8], reg_wdata[15:8], reg_be[1]),
                           merge_byte(baud_r[7:0],  reg_wdata[7:0],  reg_be[0])};
            end
            if (wr_irq_en_s) begin
                irq_en_r <= reg_wdata[4:0];
            end
        end
    end

endmodule

// File: tb/tb_uart_reg_block.sv
module tb_uart_reg_block;

    logic        pclk;
    logic        presetn;
    logic [31:0] reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic        reg_we;
    logic        reg_re;
    logic [31:0] reg_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_frame_err;
    logic        tx_en;
    logic        rx_en;
    logic [15:0] baud_div;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] rd;
    logic [31:0] rd_setup;

    uart_reg_block #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(16), .BAUD_RESET(16'd868)
    ) dut (
        .pclk(pclk), .presetn(presetn), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_be(reg_be), .reg_we(reg_we),
        .reg_re(reg_re), .reg_rdata(reg_rdata), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_frame_err(rx_frame_err), .tx_en(tx_en),
        .rx_en(rx_en), .baud_div(baud_div), .irq(irq)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Look at a register without reg_re, so nothing is popped.
    task automatic peek(input logic [31:0] addr, input string tag, input logic [31:0] exp);
        reg_addr = addr;
        #1;
        check(tag, reg_rdata, exp);
        step();
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        reg_addr  = addr;
        reg_wdata = data;
        reg_be    = be;
        reg_we    = 1'b1;
        step();
        reg_we    = 1'b0;
        reg_be    = 4'b0000;
    endtask

    // Two-cycle read: setup then access; optionally keep reg_re high for back-to-back.
    task automatic bus_read(input logic [31:0] addr, input bit hold,
                            output logic [31:0] data, output logic [31:0] setup_data);
        reg_addr = addr;
        reg_re   = 1'b1;
        #1;
        setup_data = reg_rdata;
        step();
        data = reg_rdata;
        step();
        if (!hold) begin
            reg_re = 1'b0;
        end
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    initial begin
        presetn = 1'b0; reg_addr = 32'h0; reg_wdata = 32'h0; reg_be = 4'h0;
        reg_we = 1'b0; reg_re = 1'b0; tx_ready = 1'b0; rx_data = 8'h00;
        rx_valid = 1'b0; rx_frame_err = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        presetn = 1'b1;
        step();

        // Reset state
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("rst_baud_div", {16'b0, baud_div}, 32'h0000_0364);
        peek(32'h0C, "rst_BAUD", 32'h0000_0364);
        peek(32'h08, "rst_CTRL", 32'h0);
        peek(32'h04, "rst_STATUS", 32'h0000_000A);
        peek(32'h14, "rst_IRQ_STAT", 32'h0000_0002);

        // TX path
        bus_write(32'h08, 32'h1, 4'h1);
        bus_write(32'h00, 32'h41, 4'h1);
        bus_write(32'h00, 32'h42, 4'h1);
        peek(32'h04, "tx2_STATUS", 32'h0000_0208);
        check("tx_head_41", {24'b0, tx_data}, 32'h41);
        check("tx_valid_q", {31'b0, tx_valid}, 32'h1);
        tx_ready = 1'b1;
        step();
        check("tx_second_42", {24'b0, tx_data}, 32'h42);
        check("tx_valid_2nd", {31'b0, tx_valid}, 32'h1);
        step();
        check("tx_valid_drain", {31'b0, tx_valid}, 32'h0);
        tx_ready = 1'b0;
        peek(32'h04, "tx_drained_STATUS", 32'h0000_000A);

        // DATA write without byte 0 enable does not push
        bus_write(32'h00, 32'h77, 4'b0010);
        peek(32'h04, "be_nopush_STATUS", 32'h0000_000A);

        // RX path with back-to-back reads
        bus_write(32'h08, 32'h3, 4'h1);
        rx_push(8'h5A);
        rx_push(8'hA5);
        peek(32'h04, "rx2_STATUS", 32'h0002_0002);
        bus_read(32'h00, 1'b1, rd, rd_setup);
        check("rx_read1", rd, 32'h0000_015A);
        check("rx_read1_stable", rd_setup, 32'h0000_015A);
        bus_read(32'h00, 1'b0, rd, rd_setup);
        check("rx_read2", rd, 32'h0000_01A5);
        check("rx_read2_stable", rd_setup, 32'h0000_01A5);
        peek(32'h04, "rx0_STATUS", 32'h0000_000A);
        bus_read(32'h00, 1'b0, rd, rd_setup);
        check("rx_read3_empty", rd, 32'h0000_00A5);
        peek(32'h04, "rx_nopop_STATUS", 32'h0000_000A);

        // RX overrun and interrupt
        bus_write(32'h10, 32'h04, 4'h1);
        for (int i = 0; i < 16; i++) begin
            rx_push(8'h10 + 8'(i));
        end
        peek(32'h04, "rx_full_STATUS", 32'h0010_0006);
        peek(32'h14, "rx_full_IRQ_STAT", 32'h0000_0003);
        check("irq_before_ovr", {31'b0, irq}, 32'h0);
        rx_push(8'hEE);
        check("irq_latency", {31'b0, irq}, 32'h0);
        peek(32'h14, "ovr_IRQ_STAT", 32'h0000_0007);
        check("irq_ovr", {31'b0, irq}, 32'h1);
        peek(32'h04, "ovr_count_STATUS", 32'h0010_0006);
        peek(32'h00, "ovr_head_DATA", 32'h0000_0110);
        bus_write(32'h14, 32'h04, 4'h1);
        check("irq_w1c_lag", {31'b0, irq}, 32'h1);
        peek(32'h14, "w1c_IRQ_STAT", 32'h0000_0003);
        check("irq_fall", {31'b0, irq}, 32'h0);

        // Sticky set coincides with W1C: set wins
        rx_valid = 1'b1;
        rx_data  = 8'h99;
        bus_write(32'h14, 32'h04, 4'h1);
        rx_valid = 1'b0;
        peek(32'h14, "setwins_IRQ_STAT", 32'h0000_0007);
        bus_write(32'h14, 32'h04, 4'h1);
        peek(32'h14, "setwins_clr_IRQ_STAT", 32'h0000_0003);

        // RX clear with simultaneous push into full FIFO: clear wins, no overrun
        rx_valid = 1'b1;
        bus_write(32'h08, 32'h0B, 4'h1);
        rx_valid = 1'b0;
        peek(32'h04, "rxclr_STATUS", 32'h0000_000A);
        peek(32'h14, "rxclr_IRQ_STAT", 32'h0000_0002);
        peek(32'h08, "rxclr_CTRL", 32'h0000_0003);

        // Frame error pulse
        rx_frame_err = 1'b1;
        step();
        rx_frame_err = 1'b0;
        peek(32'h14, "ferr_IRQ_STAT", 32'h0000_000A);
        bus_write(32'h14, 32'h08, 4'h1);
        peek(32'h14, "ferr_clr_IRQ_STAT", 32'h0000_0002);

        // TX clear with 3 bytes queued
        bus_write(32'h08, 32'h2, 4'h1);
        for (int i = 0; i < 3; i++) begin
            bus_write(32'h00, 32'h60 + 32'(i), 4'h1);
        end
        peek(32'h04, "tx3_STATUS", 32'h0000_0308);
        check("tx_valid_disabled", {31'b0, tx_valid}, 32'h0);
        bus_write(32'h08, 32'h6, 4'h1);
        peek(32'h04, "txclr_STATUS", 32'h0000_000A);
        peek(32'h08, "txclr_CTRL", 32'h0000_0002);
        peek(32'h14, "txclr_IRQ_STAT", 32'h0000_0002);

        // TX overflow
        for (int i = 0; i < 17; i++) begin
            bus_write(32'h00, 32'(i), 4'h1);
        end
        peek(32'h04, "txfull_STATUS", 32'h0000_1009);
        peek(32'h14, "txovf_IRQ_STAT", 32'h0000_0010);

        // BAUD byte enables and unmapped offset
        bus_write(32'h0C, 32'h1234, 4'b0001);
        check("baud_be0", {16'b0, baud_div}, 32'h0000_0334);
        peek(32'h0C, "baud_be0_rd", 32'h0000_0334);
        bus_write(32'h0C, 32'h1234, 4'b0010);
        peek(32'h0C, "baud_be1_rd", 32'h0000_1234);
        peek(32'h18, "unmapped_rd", 32'h0);
        bus_write(32'h18, 32'hFFFF_FFFF, 4'hF);
        peek(32'h08, "unmapped_wr_CTRL", 32'h0000_0002);

        // Reset asserted mid-run
        presetn = 1'b0;
        #1;
        check("mid_rst_baud", {16'b0, baud_div}, 32'h0000_0364);
        check("mid_rst_irq", {31'b0, irq}, 32'h0);
        peek(32'h04, "mid_rst_STATUS", 32'h0000_000A);
        peek(32'h14, "mid_rst_IRQ_STAT", 32'h0000_0002);
        presetn = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
